// File: rtl/sdram_rw_check.sv
// rtl/sdram_rw_check.sv - SDRAM write/read-back pattern checker
// Writes 1..DEPTH through the write FIFO, reads the words back in order and counts mismatches.
module sdram_rw_check #(
    parameter int DEPTH    = 1024,
    parameter int DATA_W   = 16,
    parameter int INIT_DLY = 16,
    parameter int LOOP     = 0
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              sdram_init_done,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              rd_en,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              error_flag,
    output logic [7:0]        err_cnt,
    output logic              test_done
);

    localparam int IDX_W = $clog2(DEPTH + 1);
    localparam int SET_W = (INIT_DLY > 1) ? $clog2(INIT_DLY) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((INIT_DLY > 0) ? INIT_DLY - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] END_IDX     = IDX_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, SETTLE, WRITE, READ, DONE} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] wr_idx, rd_idx, chk_idx;
    logic [SET_W-1:0] settle_cnt;
    logic             chk_fire;
    logic             abort;
    logic             mismatch;

    assign mismatch = (rd_data != DATA_W'(chk_idx + IDX_W'(1)));

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_data    = '0;
        rd_en      = 1'b0;
        chk_fire   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (sdram_init_done) state_next = SETTLE;
            end
            SETTLE: begin
                if (!sdram_init_done) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en   = wr_ready;
                wr_data = DATA_W'(wr_idx + IDX_W'(1));
                if (!sdram_init_done) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (wr_ready && (wr_idx == LAST_IDX)) begin
                    state_next = READ;
                end
            end
            READ: begin
                rd_en = rd_ready && (rd_idx < END_IDX);
                if (!sdram_init_done) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    // Returns beyond the last expected word are stale and must not be scored
                    chk_fire = rd_valid && (chk_idx < END_IDX);
                    if (chk_fire && (chk_idx == LAST_IDX)) state_next = DONE;
                end
            end
            DONE: begin
                if (LOOP != 0) state_next = WRITE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state      <= IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            chk_idx    <= '0;
            settle_cnt <= '0;
            error_flag <= 1'b0;
            err_cnt    <= 8'd0;
            test_done  <= 1'b0;
        end else begin
            state      <= state_next;
            settle_cnt <= (state == SETTLE && state_next == SETTLE) ? settle_cnt + SET_W'(1) : '0;
            if (abort || state == IDLE || (state == DONE && state_next == WRITE)) begin
                wr_idx  <= '0;
                rd_idx  <= '0;
                chk_idx <= '0;
            end else begin
                if (wr_en && wr_ready) wr_idx <= wr_idx + IDX_W'(1);
                if (rd_en && rd_ready) rd_idx <= rd_idx + IDX_W'(1);
                if (chk_fire) chk_idx <= chk_idx + IDX_W'(1);
            end
            if (chk_fire && mismatch) begin
                error_flag <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            if (state == READ && state_next == DONE) test_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_rw_check.sv
// tb/tb_sdram_rw_check.sv - self-checking bench for sdram_rw_check
// Behavioural memory with random ready, in-flight limit, latency and word corruption.
module tb_sdram_rw_check;

    localparam int DEPTH    = 8;
    localparam int DATA_W   = 16;
    localparam int INIT_DLY = 4;

    logic clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    logic              rst, sdram_init_done, wr_ready, wr_en, rd_ready, rd_en, rd_valid;
    logic              error_flag, test_done;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [7:0]        err_cnt;

    logic              rst_l, init_l, wr_ready_l, wr_en_l, rd_ready_l, rd_en_l, rd_valid_l;
    logic              error_flag_l, test_done_l;
    logic [DATA_W-1:0] wr_data_l, rd_data_l;
    logic [7:0]        err_cnt_l;

    sdram_rw_check #(.DEPTH(DEPTH), .DATA_W(DATA_W), .INIT_DLY(INIT_DLY), .LOOP(0)) dut (
        .clk_50m(clk_50m), .rst(rst), .sdram_init_done(sdram_init_done),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_data(wr_data),
        .rd_ready(rd_ready), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .error_flag(error_flag), .err_cnt(err_cnt), .test_done(test_done)
    );

    sdram_rw_check #(.DEPTH(DEPTH), .DATA_W(DATA_W), .INIT_DLY(INIT_DLY), .LOOP(1)) dut_loop (
        .clk_50m(clk_50m), .rst(rst_l), .sdram_init_done(init_l),
        .wr_ready(wr_ready_l), .wr_en(wr_en_l), .wr_data(wr_data_l),
        .rd_ready(rd_ready_l), .rd_en(rd_en_l), .rd_valid(rd_valid_l), .rd_data(rd_data_l),
        .error_flag(error_flag_l), .err_cnt(err_cnt_l), .test_done(test_done_l)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    int passed = 0;
    int total  = 0;

    ret_t              pipe[$];
    logic [DATA_W-1:0] mem[DEPTH];
    int wptr = 0, rptr = 0, nwr = 0, nrd = 0, nret = 0, wr_bad = 0, viol = 0, cyc = 0;
    int lat = 2, max_fl = 3, corrupt_idx = -1;
    bit rnd = 1'b0;
    int nwr_l = 0, wr_bad_l = 0, first_done_err = -1;
    bit seen_done_l = 1'b0, td_fell_l = 1'b0;
    logic rd_pend_l = 1'b0;

    // Memory model: inputs change on the falling edge, transfers are tallied just before the rising edge
    initial begin : model
        ret_t r;
        wr_ready = 1'b0; rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        wr_ready_l = 1'b0; rd_ready_l = 1'b0; rd_valid_l = 1'b0; rd_data_l = '0;
        forever begin
            @(negedge clk_50m);
            cyc++;
            rd_valid = 1'b0;
            rd_data  = '0;
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                r = pipe.pop_front();
                rd_valid = 1'b1;
                rd_data  = r.data;
                nret++;
            end
            wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready = (pipe.size() < max_fl) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            rd_valid_l = rd_pend_l;
            rd_data_l  = '0;
            wr_ready_l = 1'b1;
            rd_ready_l = 1'b1;
            #1;
            if (wr_en && !wr_ready) viol++;
            if (rd_en && !rd_ready) viol++;
            if (wr_en && wr_ready) begin
                if (wr_data !== DATA_W'(wptr + 1)) wr_bad++;
                mem[wptr] = wr_data;
                wptr = (wptr + 1) % DEPTH;
                nwr++;
            end
            if (rd_en && rd_ready) begin
                r.due  = cyc + lat;
                r.data = (rptr == corrupt_idx) ? '0 : mem[rptr];
                pipe.push_back(r);
                rptr = (rptr + 1) % DEPTH;
                nrd++;
            end
            rd_pend_l = rd_en_l && rd_ready_l;
            if (wr_en_l && wr_ready_l) begin
                if (wr_data_l !== DATA_W'((nwr_l % DEPTH) + 1)) wr_bad_l++;
                nwr_l++;
            end
            if (test_done_l && !seen_done_l) begin
                seen_done_l    = 1'b1;
                first_done_err = int'(err_cnt_l);
            end
            if (!test_done_l && seen_done_l) td_fell_l = 1'b1;
        end
    end

    task automatic model_clear();
        pipe.delete();
        wptr = 0; rptr = 0; nwr = 0; nrd = 0; nret = 0; wr_bad = 0; viol = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sdram_init_done = 1'b0;
        repeat (3) @(negedge clk_50m);
        #5;
        model_clear();
        rst = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_50m);
            #2;
            if (test_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic cycles_to_first_write(output int n, output logic [DATA_W-1:0] first);
        n = 0;
        first = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_50m);
            #2;
            n++;
            if (wr_data != '0) begin
                first = wr_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sdram_init_done = 1'b1;
        repeat (2) @(negedge clk_50m);
        #2;
        total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", wr_en); else passed++;
        total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %0b want 0", rd_en); else passed++;
        total++; if (wr_data !== '0) $display("FAIL reset_wr_data: got %0h want 0", wr_data); else passed++;
        total++; if (error_flag !== 1'b0) $display("FAIL reset_error_flag: got %0b want 0", error_flag); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else passed++;
        total++; if (test_done !== 1'b0) $display("FAIL reset_test_done: got %0b want 0", test_done); else passed++;
        total++; if (err_cnt_l !== 8'd0) $display("FAIL reset_loop_err_cnt: got %0d want 0", err_cnt_l); else passed++;
    endtask

    task automatic test_basic_pass();
        int n;
        bit ok;
        int hold_bad;
        logic [DATA_W-1:0] first;
        do_reset();
        rnd = 1'b0; lat = 2; max_fl = 3; corrupt_idx = -1;
        @(negedge clk_50m);
        sdram_init_done = 1'b1;
        cycles_to_first_write(n, first);
        total++; if (n !== 5) $display("FAIL basic_first_write_delay: got %0d want 5", n); else passed++;
        total++; if (first !== 16'd1) $display("FAIL basic_first_wr_data: got %0d want 1", first); else passed++;
        run_until_done(300, ok);
        total++; if (!ok) $display("FAIL basic_done_timeout: got test_done=%0b want 1", test_done); else passed++;
        hold_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_50m);
            #2;
            if (wr_en || rd_en || !test_done) hold_bad++;
        end
        total++; if (hold_bad != 0) $display("FAIL basic_done_hold: got %0d bad cycles want 0", hold_bad); else passed++;
        total++; if (nwr != DEPTH || nrd != DEPTH) $display("FAIL basic_counts: got wr=%0d rd=%0d want %0d", nwr, nrd, DEPTH); else passed++;
        total++; if (wr_bad != 0) $display("FAIL basic_wr_data: got %0d bad words want 0", wr_bad); else passed++;
        total++; if (error_flag !== 1'b0 || err_cnt !== 8'd0) $display("FAIL basic_errors: got flag=%0b cnt=%0d want 0/0", error_flag, err_cnt); else passed++;
    endtask

    task automatic test_corrupt_word();
        bit ok;
        do_reset();
        rnd = 1'b0; lat = 2; max_fl = 3; corrupt_idx = 3;
        sdram_init_done = 1'b1;
        run_until_done(300, ok);
        total++; if (!ok) $display("FAIL corrupt_done_timeout: got test_done=%0b want 1", test_done); else passed++;
        total++; if (error_flag !== 1'b1) $display("FAIL corrupt_error_flag: got %0b want 1", error_flag); else passed++;
        total++; if (err_cnt !== 8'd1) $display("FAIL corrupt_err_cnt: got %0d want 1", err_cnt); else passed++;
    endtask

    task automatic test_final_mismatch();
        bit ok;
        logic prev_ef;
        do_reset();
        rnd = 1'b0; lat = 3; max_fl = 2; corrupt_idx = DEPTH - 1;
        sdram_init_done = 1'b1;
        ok = 1'b0;
        prev_ef = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50m);
            #2;
            if (test_done) begin
                ok = 1'b1;
                break;
            end
            prev_ef = error_flag;
        end
        total++; if (!ok) $display("FAIL final_done_timeout: got test_done=%0b want 1", test_done); else passed++;
        total++; if (prev_ef !== 1'b0 || error_flag !== 1'b1) $display("FAIL final_same_edge: got before=%0b at_done=%0b want 0/1", prev_ef, error_flag); else passed++;
        total++; if (err_cnt !== 8'd1) $display("FAIL final_err_cnt: got %0d want 1", err_cnt); else passed++;
    endtask

    task automatic test_random_ready();
        bit ok;
        do_reset();
        rnd = 1'b1; lat = 5; max_fl = 3; corrupt_idx = -1;
        sdram_init_done = 1'b1;
        run_until_done(3000, ok);
        repeat (8) @(negedge clk_50m);
        #2;
        total++; if (!ok) $display("FAIL random_done_timeout: got test_done=%0b want 1", test_done); else passed++;
        total++; if (nwr != DEPTH || nrd != DEPTH) $display("FAIL random_counts: got wr=%0d rd=%0d want %0d", nwr, nrd, DEPTH); else passed++;
        total++; if (viol != 0) $display("FAIL random_ready_violation: got %0d want 0", viol); else passed++;
        total++; if (wr_bad != 0) $display("FAIL random_wr_data: got %0d bad words want 0", wr_bad); else passed++;
        total++; if (error_flag !== 1'b0 || err_cnt !== 8'd0) $display("FAIL random_errors: got flag=%0b cnt=%0d want 0/0", error_flag, err_cnt); else passed++;
    endtask

    task automatic test_abort_in_read();
        bit ok;
        int n;
        logic [DATA_W-1:0] first;
        do_reset();
        rnd = 1'b0; lat = 2; max_fl = 3; corrupt_idx = 3;
        sdram_init_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50m);
            #2;
            if (nret >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) $display("FAIL abort_reach_read_timeout: got nret=%0d want 4", nret); else passed++;
        @(negedge clk_50m);
        sdram_init_done = 1'b0;
        @(negedge clk_50m);
        #2;
        total++; if (wr_en !== 1'b0 || rd_en !== 1'b0) $display("FAIL abort_idle_strobes: got wr_en=%0b rd_en=%0b want 0/0", wr_en, rd_en); else passed++;
        total++; if (error_flag !== 1'b1 || err_cnt !== 8'd1) $display("FAIL abort_error_retained: got flag=%0b cnt=%0d want 1/1", error_flag, err_cnt); else passed++;
        total++; if (test_done !== 1'b0) $display("FAIL abort_test_done: got %0b want 0", test_done); else passed++;
        repeat (8) @(negedge clk_50m);
        #5;
        model_clear();
        sdram_init_done = 1'b1;
        cycles_to_first_write(n, first);
        total++; if (first !== 16'd1) $display("FAIL abort_restart_wr_data: got %0d want 1", first); else passed++;
        run_until_done(300, ok);
        total++; if (!ok || nwr != DEPTH || wr_bad != 0) $display("FAIL abort_repass: got done=%0b wr=%0d bad=%0d want 1/%0d/0", ok, nwr, wr_bad, DEPTH); else passed++;
        total++; if (error_flag !== 1'b1 || err_cnt !== 8'd2) $display("FAIL abort_repass_errors: got flag=%0b cnt=%0d want 1/2", error_flag, err_cnt); else passed++;
    endtask

    task automatic test_reset_in_write();
        bit ok;
        int n;
        logic [DATA_W-1:0] first;
        do_reset();
        rnd = 1'b1; lat = 2; max_fl = 3; corrupt_idx = 2;
        sdram_init_done = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_50m);
            #2;
            if (nwr >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) $display("FAIL rstwr_reach_timeout: got nwr=%0d want 5", nwr); else passed++;
        @(negedge clk_50m);
        rst = 1'b1;
        @(negedge clk_50m);
        #2;
        total++; if (wr_en !== 1'b0 || rd_en !== 1'b0 || wr_data !== '0) $display("FAIL rstwr_strobes: got wr_en=%0b rd_en=%0b wr_data=%0h want 0", wr_en, rd_en, wr_data); else passed++;
        total++; if (error_flag !== 1'b0 || err_cnt !== 8'd0 || test_done !== 1'b0) $display("FAIL rstwr_status: got flag=%0b cnt=%0d done=%0b want 0", error_flag, err_cnt, test_done); else passed++;
        #3;
        model_clear();
        corrupt_idx = -1;
        rst = 1'b0;
        cycles_to_first_write(n, first);
        total++; if (n !== 5 || first !== 16'd1) $display("FAIL rstwr_restart: got delay=%0d wr_data=%0d want 5/1", n, first); else passed++;
        run_until_done(3000, ok);
        total++; if (!ok || nwr != DEPTH || wr_bad != 0 || error_flag !== 1'b0) $display("FAIL rstwr_repass: got done=%0b wr=%0d bad=%0d flag=%0b want 1/%0d/0/0", ok, nwr, wr_bad, error_flag, DEPTH); else passed++;
    endtask

    task automatic test_loop_saturate();
        bit ok;
        @(negedge clk_50m);
        #5;
        init_l = 1'b1;
        rst_l  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_50m);
            #2;
            if (nwr_l >= 40 * DEPTH) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) $display("FAIL loop_timeout: got writes=%0d want %0d", nwr_l, 40 * DEPTH); else passed++;
        total++; if (first_done_err != DEPTH) $display("FAIL loop_first_pass_errs: got %0d want %0d", first_done_err, DEPTH); else passed++;
        total++; if (err_cnt_l !== 8'd255) $display("FAIL loop_err_cnt_sat: got %0d want 255", err_cnt_l); else passed++;
        total++; if (error_flag_l !== 1'b1) $display("FAIL loop_error_flag: got %0b want 1", error_flag_l); else passed++;
        total++; if (test_done_l !== 1'b1 || td_fell_l) $display("FAIL loop_test_done_sticky: got done=%0b fell=%0b want 1/0", test_done_l, td_fell_l); else passed++;
        total++; if (wr_bad_l != 0) $display("FAIL loop_wr_data_restart: got %0d bad words want 0", wr_bad_l); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        sdram_init_done = 1'b0;
        rst_l = 1'b1;
        init_l = 1'b0;
        test_reset();
        test_basic_pass();
        test_corrupt_word();
        test_final_mismatch();
        test_random_ready();
        test_abort_in_read();
        test_reset_in_write();
        test_loop_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sdram_rw_check.md
SDRAM_RW_CHECK -- requirements
Module: sdram_rw_check

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of words written and then read back per pass (2..65535).
REQ-002 SHALL have parameter DATA_W, default 16, meaning the data word width.
REQ-003 SHALL have parameter INIT_DLY, default 16, meaning the settle cycles after sdram_init_done before the first write.
REQ-004 SHALL have parameter LOOP, default 0, meaning 0 runs a single pass and 1 repeats passes indefinitely.
REQ-005 SHALL have port clk_50m, input, width 1: the single system clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-007 SHALL have port sdram_init_done, input, width 1: high while the SDRAM controller is initialised.
REQ-008 SHALL have port wr_ready, input, width 1: the write FIFO can accept a word this cycle.
REQ-009 SHALL have port wr_en, output, width 1: write strobe; a word transfers when wr_en and wr_ready are both high.
REQ-010 SHALL have port wr_data, output, width DATA_W: the write word.
REQ-011 SHALL have port rd_ready, input, width 1: a read may be issued this cycle.
REQ-012 SHALL have port rd_en, output, width 1: read request; it is accepted when rd_en and rd_ready are both high.
REQ-013 SHALL have port rd_valid, input, width 1: rd_data is valid this cycle.
REQ-014 SHALL have port rd_data, input, width DATA_W: the read-back word.
REQ-015 SHALL have port error_flag, output, width 1: sticky mismatch indicator, consumed by the LED display stage.
REQ-016 SHALL have port err_cnt, output, width 8: mismatch count, saturating at 255.
REQ-017 SHALL have port test_done, output, width 1: high after a pass completes.

Function
REQ-018 SHALL implement states IDLE, SETTLE, WRITE, READ, DONE.
REQ-019 IDLE -> SETTLE when sdram_init_done=1.
REQ-020 SETTLE SHALL count INIT_DLY cycles, then go to WRITE.
REQ-021 WRITE SHALL assert wr_en combinationally equal to wr_ready, with wr_data = wr_idx+1 truncated to DATA_W bits; wr_idx starts at 0.
REQ-022 wr_idx SHALL increment only on an accepted transfer; after transfer DEPTH-1 the block enters READ the next cycle, with no wr_en in READ.
REQ-023 READ SHALL assert rd_en = rd_ready while rd_idx < DEPTH; rd_idx increments per accepted request.
REQ-024 Multiple reads SHALL be allowed in flight; returns are consumed in order via chk_idx.
REQ-025 On rd_valid in READ, the block SHALL compare rd_data against chk_idx+1 truncated to DATA_W bits; on mismatch it sets error_flag and increments err_cnt (saturating); chk_idx then increments.
REQ-026 When chk_idx reaches DEPTH, the block SHALL enter DONE and set test_done the same edge.
REQ-027 rd_valid SHALL be ignored outside READ and ignored once chk_idx = DEPTH.
REQ-028 DONE with LOOP=0 SHALL hold forever; wr_en and rd_en stay low.
REQ-029 DONE with LOOP=1 SHALL return to WRITE after 1 cycle with all indices cleared; test_done stays high, and error_flag and err_cnt are retained.
REQ-030 If sdram_init_done falls in SETTLE, WRITE, or READ, the block SHALL abort to IDLE and clear its indices; error_flag, err_cnt, and test_done are retained.
REQ-031 A mismatch on the final compare SHALL set error_flag on the same edge as test_done.
REQ-032 error_flag SHALL be a registered output and change only on a compare or on reset.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL go to state IDLE with indices = 0, wr_en = 0, rd_en = 0, wr_data = 0, error_flag = 0, err_cnt = 0, and test_done = 0.
REQ-034 rst SHALL take priority over every other input, including mid-pass, and the first edge after release SHALL evaluate IDLE.

Verification
REQ-035 DEPTH=8, INIT_DLY=4, ideal memory model -> the first wr_en comes 5 cycles after init_done; wr_data is 1..8; test_done=1; error_flag=0; err_cnt=0.
REQ-036 Model corrupts read word 3 (returns 0x0000 instead of 0x0004) -> error_flag=1 after that rd_valid; err_cnt=1; test_done=1.
REQ-037 Toggle wr_ready/rd_ready at random, 3 reads in flight, read latency 5 -> exactly 8 writes and 8 reads; no transfer while ready=0; pass clean.
REQ-038 Drop init_done during READ at chk_idx=4 -> return to IDLE; on reassert the pass restarts at wr_data=1; prior error_flag is retained.
REQ-039 LOOP=1, every word corrupt, 40 passes of 8 -> err_cnt saturates at 255; error_flag=1.
REQ-040 Assert rst during WRITE at wr_idx=5 -> on the next edge all outputs are 0; the pass restarts from IDLE.
